button_arbiter: RTL

BUTTON_ARBITER -- requirements
Module: button_arbiter

---
 rtl/button_pkg.sv | 22 ++
 rtl/press_edge.sv | 30 +++
 rtl/button_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and helpers for the reaction-game button arbiter.
package button_pkg;

    // Round phases of the arbiter.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_GO     = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // Width of the shared phase counter: enough bits to hold the largest
    // (duration - 1) of the three timed phases.
    function automatic int cnt_width(input int arm, input int go, input int hold);
        int m;
        m = arm;
        if (go > m)   m = go;
        if (hold > m) m = hold;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/press_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// press pulses for one cycle, two clocks after the first edge that samples
// button high; a button that stays high produces no further pulses.
module press_edge (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);

    logic sync1;
    logic sync2;
    logic prev;

    // Synchronize the raw button and register its rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            prev  <= sync2;
            press <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/button_arbiter.sv
// Reaction-game button arbiter: IDLE -> ARMED -> GO -> LOCKED -> IDLE.
// The first eligible press in GO wins; simultaneous presses are resolved
// round-robin. Optional false-start detection is enabled by defining the
// macro FALSE_START_EN (a press in ARMED disqualifies that player for the
// round; if every player is disqualified the round is abandoned).
module button_arbiter
    import button_pkg::*;
#(
    parameter int N_PLAYERS   = 4,
    parameter int ARM_CYCLES  = 1000000,
    parameter int GO_CYCLES   = 5000000,
    parameter int HOLD_CYCLES = 2000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_PLAYERS-1:0] button,
    output logic                 go,
    output logic [N_PLAYERS-1:0] winner,
    output logic                 winner_valid,
    output logic                 timeout,
    output logic [N_PLAYERS-1:0] disq,
    output logic                 busy
);

    localparam int CW = cnt_width(ARM_CYCLES, GO_CYCLES, HOLD_CYCLES);
    localparam int PW = 3;

    state_t                 state;
    logic [CW-1:0]          count;
    logic [PW-1:0]          rr_ptr;
    logic [N_PLAYERS-1:0]   press;
    logic [N_PLAYERS-1:0]   eligible;
    logic [2*N_PLAYERS-1:0] rot_full;
    logic [N_PLAYERS-1:0]   rot;
    logic                   found;
    int                     pick_idx;
    logic [N_PLAYERS-1:0]   pick_onehot;
    logic                   all_disq;

    genvar gi;
    generate
        for (gi = 0; gi < N_PLAYERS; gi++) begin : g_press
            press_edge u_press_edge (
                .clk    (clk),
                .rst    (rst),
                .button (button[gi]),
                .press  (press[gi])
            );
        end
    endgenerate

    assign go       = (state == ST_GO);
    assign busy     = (state != ST_IDLE);
    assign eligible = press & ~disq;

    // Rotate the eligible vector so the search always starts at rr_ptr.
    assign rot_full = {eligible, eligible} >> rr_ptr;
    assign rot      = rot_full[N_PLAYERS-1:0];

    // Round-robin pick: first eligible player at or above rr_ptr, with wrap.
    always_comb begin
        found       = 1'b0;
        pick_idx    = 0;
        pick_onehot = '0;
        for (int k = 0; k < N_PLAYERS; k++) begin
            if (!found && rot[k]) begin
                found    = 1'b1;
                pick_idx = (int'(rr_ptr) + k) % N_PLAYERS;
            end
        end
        for (int j = 0; j < N_PLAYERS; j++) begin
            pick_onehot[j] = found && (j == pick_idx);
        end
    end

`ifdef FALSE_START_EN
    assign all_disq = &disq;

    // Latch false starts made during ARMED; cleared when a new round starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disq <= '0;
        end else if (state == ST_IDLE && start) begin
            disq <= '0;
        end else if (state == ST_ARMED) begin
            disq <= disq | press;
        end
    end
`else
    assign all_disq = 1'b0;
    assign disq     = '0;
`endif

    // Round state machine with a single shared down-counter per phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            count        <= '0;
            rr_ptr       <= '0;
            winner       <= '0;
            winner_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_ARMED;
                        count <= CW'(ARM_CYCLES - 1);
                    end
                end
                ST_ARMED: begin
                    if (all_disq) begin
                        state <= ST_IDLE;
                    end else if (count == '0) begin
                        state <= ST_GO;
                        count <= CW'(GO_CYCLES - 1);
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                ST_GO: begin
                    if (found) begin
                        state        <= ST_LOCKED;
                        count        <= CW'(HOLD_CYCLES - 1);
                        winner       <= pick_onehot;
                        winner_valid <= 1'b1;
                        rr_ptr       <= PW'((pick_idx + 1) % N_PLAYERS);
                    end else if (count == '0) begin
                        state   <= ST_LOCKED;
                        count   <= CW'(HOLD_CYCLES - 1);
                        timeout <= 1'b1;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (count == '0) begin
                        state        <= ST_IDLE;
                        winner       <= '0;
                        winner_valid <= 1'b0;
                        timeout      <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
